// File: rtl/parking_allocator.sv
// Parking-slot allocator: registered occupancy map with lowest-index-first or
// round-robin grant policy, exit handling, free count and misuse reporting.
module parking_allocator #(
  parameter int N_SPOTS    = 8,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 4,
  parameter int ALLOC_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic [IDX_W-1:0]   exit_spot,
  output logic               entry_ack,
  output logic               entry_nack,
  output logic [IDX_W-1:0]   park_number,
  output logic [N_SPOTS-1:0] occupied,
  output logic [CNT_W-1:0]   free_count,
  output logic               full,
  output logic               empty,
  output logic               exit_err
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   start_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   low_idx;
  logic               upper_hit;
  logic               any_free;
  logic               do_grant;
  logic               exit_ok;
  logic [N_SPOTS-1:0] grant_mask;
  logic [N_SPOTS-1:0] exit_mask;
  logic [CNT_W-1:0]   next_count;

  // Two-pass search: lowest free slot at or above the start index, else the
  // lowest free slot overall, which gives the circular wrap.
  always_comb begin
    start_idx = (ALLOC_MODE == 1) ? rr_ptr : '0;
    upper_hit = 1'b0;
    any_free  = 1'b0;
    sel_idx   = '0;
    low_idx   = '0;
    for (int i = N_SPOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        any_free = 1'b1;
        low_idx  = IDX_W'(i);
        if (IDX_W'(i) >= start_idx) begin
          upper_hit = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end
    if (!upper_hit) begin
      sel_idx = low_idx;
    end
  end

  assign do_grant = entry_req && any_free;

  always_comb begin
    grant_mask = '0;
    exit_mask  = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      grant_mask[i] = do_grant && (sel_idx == IDX_W'(i));
      exit_mask[i]  = exit_req && (exit_spot == IDX_W'(i)) && occupied[i];
    end
  end

  assign exit_ok = |exit_mask;

  always_comb begin
    next_count = free_count;
    if (exit_ok && !do_grant) begin
      next_count = free_count + CNT_W'(1);
    end else if (do_grant && !exit_ok) begin
      next_count = free_count - CNT_W'(1);
    end
  end

  // Grant and exit masks never overlap: a granted slot was free before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied    <= '0;
      free_count  <= CNT_W'(N_SPOTS);
      full        <= 1'b0;
      empty       <= 1'b1;
      park_number <= '0;
      entry_ack   <= 1'b0;
      entry_nack  <= 1'b0;
      exit_err    <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      occupied    <= (occupied | grant_mask) & ~exit_mask;
      free_count  <= next_count;
      full        <= (next_count == '0);
      empty       <= (next_count == CNT_W'(N_SPOTS));
      entry_ack   <= do_grant;
      entry_nack  <= entry_req && !any_free;
      exit_err    <= exit_req && !exit_ok;
      if (do_grant) begin
        park_number <= sel_idx;
        rr_ptr      <= (sel_idx == IDX_W'(N_SPOTS - 1)) ? '0 : sel_idx + IDX_W'(1);
      end
    end
  end

endmodule
